// File: rtl/hk_spi_pkg.sv
// rtl/hk_spi_pkg.sv - shared types and command decode for the housekeeping SPI pass-thru
package hk_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PASS,
        ST_FOREIGN,
        ST_DROP
    } state_e;

    localparam int         MAX_TARGETS     = 8;
    localparam logic [7:0] PT_CMD_BASE_DEF = 8'hC4;

    typedef struct packed {
        logic       match;
        logic [2:0] idx;
    } tgt_sel_t;

    // Commands below the base wrap to a large offset and so never match.
    function automatic tgt_sel_t tgt_of_cmd(input logic [7:0] cmd,
                                            input logic [7:0] base,
                                            input int         n_targets);
        tgt_sel_t   r;
        logic [7:0] off;
        off     = cmd - base;
        r.idx   = off[3:1];
        r.match = (off[0] == 1'b0) && (off[7:1] < 7'(n_targets));
        return r;
    endfunction

endpackage

// File: rtl/hk_spi_passthru_mux_sync.sv
// rtl/hk_spi_passthru_mux_sync.sv - host pin synchroniser with SCK/CSB edge pulses
module hk_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic sck_i,
    input  logic csb_i,
    input  logic sdi_i,
    output logic sck_o,
    output logic sdi_o,
    output logic sck_rise_o,
    output logic csb_fall_o,
    output logic csb_rise_o
);

    // Bit order {sck, csb, sdi}; CSB resets high so no start is seen out of reset.
    logic [2:0] stage_q [STAGES];
    logic [1:0] prev_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= 3'b010;
            end
            prev_q <= 2'b01;
        end else begin
            stage_q[0] <= {sck_i, csb_i, sdi_i};
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1][2:1];
        end
    end

    assign sck_o      = stage_q[STAGES-1][2];
    assign sdi_o      = stage_q[STAGES-1][0];
    assign sck_rise_o = stage_q[STAGES-1][2] & ~prev_q[1];
    assign csb_fall_o = ~stage_q[STAGES-1][1] & prev_q[0];
    assign csb_rise_o = stage_q[STAGES-1][1] & ~prev_q[0];

endmodule

// File: rtl/hk_spi_passthru_mux.sv
// rtl/hk_spi_passthru_mux.sv - decodes the first host SPI byte and forwards pass-thru traffic to a target
module hk_spi_passthru_mux
    import hk_spi_pkg::*;
#(
    parameter int         N_TARGETS   = 2,
    parameter logic [7:0] PT_CMD_BASE = PT_CMD_BASE_DEF,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 hk_sck,
    input  logic                 hk_csb,
    input  logic                 hk_sdi,
    output logic                 hk_sdo,
    output logic                 hk_sdo_oe,
    input  logic [N_TARGETS-1:0] target_en,
    input  logic [N_TARGETS-1:0] tgt_miso,
    output logic [N_TARGETS-1:0] tgt_csb,
    output logic [N_TARGETS-1:0] tgt_sck,
    output logic [N_TARGETS-1:0] tgt_mosi,
    output logic [2:0]           active_tgt,
    output logic                 busy,
    output logic                 hold_reset,
    output logic                 cmd_err,
    output logic [CNT_W-1:0]     byte_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic sck_s, sdi_s, sck_rise, csb_fall, csb_rise;

    hk_spi_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock      (clock),
        .resetn     (resetn),
        .sck_i      (hk_sck),
        .csb_i      (hk_csb),
        .sdi_i      (hk_sdi),
        .sck_o      (sck_s),
        .sdi_o      (sdi_s),
        .sck_rise_o (sck_rise),
        .csb_fall_o (csb_fall),
        .csb_rise_o (csb_rise)
    );

    state_e                 state_q;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             shift_q;
    logic [2:0]             tgt_q;
    logic                   sck_arm_q;
    logic [CNT_W-1:0]       byte_cnt_q;
    logic [N_TARGETS-1:0]   tgt_csb_q, tgt_sck_q, tgt_mosi_q;
    logic                   hk_sdo_q, hk_sdo_oe_q, busy_q, hold_q, cmd_err_q;

    logic [7:0]             cmd_d;
    tgt_sel_t               dec_d;
    logic                   en_d;
    logic [N_TARGETS-1:0]   sel_d, new_sel_d;

    always_comb begin
        cmd_d     = {shift_q, sdi_s};
        dec_d     = tgt_of_cmd(cmd_d, PT_CMD_BASE, N_TARGETS);
        en_d      = 1'b0;
        sel_d     = '0;
        new_sel_d = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            sel_d[i]     = (tgt_q == 3'(i));
            new_sel_d[i] = (dec_d.idx == 3'(i));
            if (dec_d.idx == 3'(i)) begin
                en_d = target_en[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tgt_q       <= '0;
            sck_arm_q   <= 1'b0;
            byte_cnt_q  <= '0;
            tgt_csb_q   <= '1;
            tgt_sck_q   <= '0;
            tgt_mosi_q  <= '0;
            hk_sdo_q    <= 1'b0;
            hk_sdo_oe_q <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q      <= 1'b0;
                    hold_q      <= 1'b0;
                    hk_sdo_oe_q <= 1'b0;
                    hk_sdo_q    <= 1'b0;
                    if (csb_fall) begin
                        state_q    <= ST_CMD;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                ST_CMD: begin
                    if (csb_rise) begin
                        state_q <= ST_IDLE;
                    end else if (sck_rise) begin
                        shift_q   <= cmd_d[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!dec_d.match) begin
                                state_q <= ST_FOREIGN;
                            end else if (!en_d) begin
                                cmd_err_q <= 1'b1;
                                state_q   <= ST_DROP;
                            end else begin
                                state_q     <= ST_PASS;
                                tgt_q       <= dec_d.idx;
                                tgt_csb_q   <= ~new_sel_d;
                                sck_arm_q   <= 1'b0;
                                busy_q      <= 1'b1;
                                hold_q      <= (dec_d.idx == 3'd0);
                                hk_sdo_oe_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    if (csb_rise) begin
                        state_q    <= ST_IDLE;
                        tgt_csb_q  <= '1;
                        tgt_sck_q  <= '0;
                        tgt_mosi_q <= '0;
                        hk_sdo_q   <= 1'b0;
                    end else begin
                        // SCK is still high from the command's last bit; forward only after it has dropped.
                        tgt_sck_q  <= sel_d & {N_TARGETS{sck_s & sck_arm_q}};
                        tgt_mosi_q <= sel_d & {N_TARGETS{sdi_s}};
                        hk_sdo_q   <= |(tgt_miso & sel_d);
                        if (!sck_s) begin
                            sck_arm_q <= 1'b1;
                        end
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7 && byte_cnt_q != '1) begin
                                byte_cnt_q <= byte_cnt_q + CNT_ONE;
                            end
                        end
                    end
                end
                ST_FOREIGN, ST_DROP: begin
                    if (csb_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hk_sdo     = hk_sdo_q;
    assign hk_sdo_oe  = hk_sdo_oe_q;
    assign tgt_csb    = tgt_csb_q;
    assign tgt_sck    = tgt_sck_q;
    assign tgt_mosi   = tgt_mosi_q;
    assign active_tgt = tgt_q;
    assign busy       = busy_q;
    assign hold_reset = hold_q;
    assign cmd_err    = cmd_err_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_hk_spi_passthru_mux.sv
// tb/tb_hk_spi_passthru_mux.sv - self-checking bench for hk_spi_passthru_mux
module tb_hk_spi_passthru_mux;

    localparam int N = 2;
    localparam int S = 2;
    localparam int H = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic        hk_sck, hk_csb, hk_sdi;
    logic        hk_sdo, hk_sdo_oe;
    logic [1:0]  target_en;
    logic [1:0]  s_miso = 2'b00;
    logic [1:0]  tgt_csb, tgt_sck, tgt_mosi;
    logic [2:0]  active_tgt;
    logic        busy, hold_reset, cmd_err;
    logic [15:0] byte_cnt;

    hk_spi_passthru_mux #(.N_TARGETS(N), .SYNC_STAGES(S)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .hk_sck     (hk_sck),
        .hk_csb     (hk_csb),
        .hk_sdi     (hk_sdi),
        .hk_sdo     (hk_sdo),
        .hk_sdo_oe  (hk_sdo_oe),
        .target_en  (target_en),
        .tgt_miso   (s_miso),
        .tgt_csb    (tgt_csb),
        .tgt_sck    (tgt_sck),
        .tgt_mosi   (tgt_mosi),
        .active_tgt (active_tgt),
        .busy       (busy),
        .hold_reset (hold_reset),
        .cmd_err    (cmd_err),
        .byte_cnt   (byte_cnt)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Downstream flash models: READ (0x03) returns flash_mem, RDID (0x9F) returns the id bytes.
    logic [7:0] flash_mem [4] = '{8'h6F, 8'h12, 8'h34, 8'h56};
    logic [7:0] flash_id  [3] = '{8'hEF, 8'h40, 8'h18};
    logic [7:0] s_rx [2]  = '{8'h00, 8'h00};
    logic [7:0] s_tx [2]  = '{8'h00, 8'h00};
    logic [7:0] s_cmd [2] = '{8'h00, 8'h00};
    int         s_nb [2]  = '{0, 0};
    int         s_nby [2] = '{0, 0};
    logic [1:0] s_csb_p = 2'b11;
    logic [1:0] s_sck_p = 2'b00;

    function automatic logic [7:0] resp(input logic [7:0] c, input int nby);
        if (c == 8'h03 && nby >= 4 && nby < 8) return flash_mem[nby-4];
        if (c == 8'h9F && nby >= 1 && nby <= 3) return flash_id[nby-1];
        return 8'hFF;
    endfunction

    initial forever begin
        @(posedge clock);
        for (int g = 0; g < 2; g++) begin
            if (!tgt_csb[g] && s_csb_p[g]) begin
                s_nb[g]  = 0;
                s_nby[g] = 0;
            end
            if (!tgt_csb[g]) begin
                if (tgt_sck[g] && !s_sck_p[g]) begin
                    s_rx[g] = {s_rx[g][6:0], tgt_mosi[g]};
                    s_nb[g]++;
                    if (s_nb[g] == 8) begin
                        s_nb[g] = 0;
                        if (s_nby[g] == 0) s_cmd[g] = s_rx[g];
                        s_nby[g]++;
                    end
                end
                if (!tgt_sck[g] && s_sck_p[g]) begin
                    if (s_nb[g] == 0) s_tx[g] = resp(s_cmd[g], s_nby[g]);
                    s_miso[g] <= s_tx[g][7-s_nb[g]];
                end
            end else begin
                s_miso[g] <= 1'b0;
            end
            s_csb_p[g] = tgt_csb[g];
            s_sck_p[g] = tgt_sck[g];
        end
    end

    logic       mon_clr   = 1'b0;
    int         err_cyc   = 0;
    logic       busy_seen = 1'b0;
    logic [2:0] tgt_seen  = '0;
    logic       hold_any  = 1'b0;
    logic       oe_any    = 1'b0;
    logic [1:0] csb_low   = '0;
    logic       sel_bad   = 1'b0;

    always @(negedge clock) begin
        if (mon_clr) begin
            err_cyc <= 0; busy_seen <= 1'b0; tgt_seen <= '0; hold_any <= 1'b0;
            oe_any <= 1'b0; csb_low <= '0; sel_bad <= 1'b0;
        end else begin
            if (cmd_err) err_cyc <= err_cyc + 1;
            if (busy) begin
                busy_seen <= 1'b1;
                tgt_seen  <= active_tgt;
            end
            hold_any <= hold_any | hold_reset;
            oe_any   <= oe_any | hk_sdo_oe;
            csb_low  <= csb_low | ~tgt_csb;
            if (tgt_csb == 2'b00) sel_bad <= 1'b1;
        end
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    task automatic host_bit(input logic b, output logic r);
        hk_sck = 1'b0;
        hk_sdi = b;
        step(H);
        r = hk_sdo;
        hk_sck = 1'b1;
        step(H);
    endtask

    task automatic host_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            host_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic csb_start();
        hk_csb = 1'b0;
        step(4);
    endtask

    task automatic csb_end();
        hk_sck = 1'b0;
        step(H);
        hk_csb = 1'b1;
        step(2 * S + 6);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [1:0] en;
        int         nbytes;
        int         xbits;
        logic [1:0] exp_csb_low;
        int         exp_cnt;
        logic       exp_hold;
        int         exp_err;
        logic       exp_oe;
    } vec_t;

    // Reference: command maps to target (cmd-0xC4)/2 when the offset is even and in range.
    function automatic vec_t model(input logic [7:0] cmd, input logic [1:0] en,
                                   input int nbytes, input int xbits);
        vec_t v;
        int   d, k;
        logic pt, pass;
        d    = int'(cmd) - 'hC4;
        k    = d / 2;
        pt   = (d >= 0) && (d % 2 == 0) && (k < N);
        pass = pt && en[pt ? k : 0];
        v.cmd         = cmd;
        v.en          = en;
        v.nbytes      = nbytes;
        v.xbits       = xbits;
        v.exp_csb_low = pass ? 2'(1 << k) : 2'b00;
        v.exp_cnt     = pass ? nbytes : 0;
        v.exp_hold    = pass && (k == 0);
        v.exp_err     = (pt && !pass) ? 1 : 0;
        v.exp_oe      = pass;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] rx, p0;
        logic       r;
        logic       pass;
        int         k;
        pass = (v.exp_csb_low != 2'b00);
        k    = v.exp_csb_low[1] ? 1 : 0;
        p0   = 8'h00;
        target_en = v.en;
        mon_clear();
        csb_start();
        host_byte(v.cmd, rx);
        for (int i = 0; i < v.nbytes; i++) begin
            logic [7:0] pb;
            pb = 8'($urandom);
            if (i == 0) p0 = pb;
            host_byte(pb, rx);
        end
        for (int i = 0; i < v.xbits; i++) host_bit(1'($urandom), r);
        csb_end();
        chk({tag, ".csb_low"}, csb_low, v.exp_csb_low);
        chk({tag, ".byte_cnt"}, byte_cnt, v.exp_cnt);
        chk({tag, ".hold"}, hold_any, v.exp_hold);
        chk({tag, ".cmd_err_cyc"}, err_cyc, v.exp_err);
        chk({tag, ".oe"}, oe_any, v.exp_oe);
        chk({tag, ".busy"}, busy_seen, pass);
        chk({tag, ".one_sel"}, sel_bad, 1'b0);
        chk({tag, ".idle_csb"}, tgt_csb, 2'b11);
        if (pass) begin
            chk({tag, ".active"}, tgt_seen, k);
            chk({tag, ".slv_bytes"}, s_nby[k], v.nbytes);
            if (v.nbytes > 0) chk({tag, ".slv_first"}, s_cmd[k], p0);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    vec_t tbl [9];

    initial begin
        logic [7:0] rx;
        logic       r;
        int         lat, gap;

        tbl[0] = '{8'hC4, 2'b11, 2, 0, 2'b01, 2, 1'b1, 0, 1'b1};
        tbl[1] = '{8'hC6, 2'b11, 1, 3, 2'b10, 1, 1'b0, 0, 1'b1};
        tbl[2] = '{8'hC6, 2'b01, 0, 0, 2'b00, 0, 1'b0, 1, 1'b0};
        tbl[3] = '{8'h80, 2'b11, 2, 0, 2'b00, 0, 1'b0, 0, 1'b0};
        tbl[4] = '{8'hC8, 2'b11, 1, 0, 2'b00, 0, 1'b0, 0, 1'b0};
        tbl[5] = '{8'hC5, 2'b11, 1, 0, 2'b00, 0, 1'b0, 0, 1'b0};
        tbl[6] = '{8'hC4, 2'b10, 1, 0, 2'b00, 0, 1'b0, 1, 1'b0};
        tbl[7] = '{8'hC4, 2'b01, 0, 5, 2'b01, 0, 1'b1, 0, 1'b1};
        tbl[8] = '{8'h44, 2'b11, 1, 2, 2'b00, 0, 1'b0, 0, 1'b0};

        resetn = 1'b0; hk_sck = 1'b0; hk_csb = 1'b1; hk_sdi = 1'b0; target_en = 2'b11;
        step(5);
        chk("reset.tgt_csb", tgt_csb, 2'b11);
        chk("reset.tgt_sck", tgt_sck, 2'b00);
        chk("reset.busy", busy, 1'b0);
        chk("reset.hold", hold_reset, 1'b0);
        chk("reset.byte_cnt", byte_cnt, 0);
        chk("reset.oe", hk_sdo_oe, 1'b0);
        chk("reset.active", active_tgt, 0);
        resetn = 1'b1;
        step(4);
        mon_clear();

        // Management flash read at address 0.
        csb_start();
        host_byte(8'hC4, rx);
        host_byte(8'h03, rx);
        for (int i = 0; i < 3; i++) host_byte(8'h00, rx);
        host_byte(8'hFF, rx);
        chk("read.data", rx, 8'h6F);
        chk("read.hold_live", hold_reset, 1'b1);
        csb_end();
        chk("read.csb_low", csb_low, 2'b01);
        chk("read.hold_any", hold_any, 1'b1);
        chk("read.byte_cnt", byte_cnt, 5);
        chk("read.hold_after", hold_reset, 1'b0);
        chk("read.busy_after", busy, 1'b0);

        // User flash id read.
        mon_clear();
        csb_start();
        host_byte(8'hC6, rx);
        host_byte(8'h9F, rx);
        host_byte(8'hFF, rx); chk("id.b0", rx, 8'hEF);
        host_byte(8'hFF, rx); chk("id.b1", rx, 8'h40);
        host_byte(8'hFF, rx); chk("id.b2", rx, 8'h18);
        csb_end();
        chk("id.active", tgt_seen, 1);
        chk("id.hold_any", hold_any, 1'b0);
        chk("id.csb_low", csb_low, 2'b10);
        chk("id.byte_cnt", byte_cnt, 4);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Abort after the command plus 3 bits; CSB rises together with the 4th SCK edge.
        target_en = 2'b11;
        csb_start();
        host_byte(8'hC4, rx);
        for (int i = 0; i < 3; i++) host_bit(1'b1, r);
        hk_sck = 1'b0; hk_sdi = 1'b0;
        step(H);
        chk("abort.csb_before", tgt_csb[0], 1'b0);
        hk_sck = 1'b1; hk_csb = 1'b1;
        lat = 0;
        while (lat < S + 4 && tgt_csb[0] !== 1'b1) begin
            step(1);
            lat++;
        end
        chk("abort.latency_ok", (lat <= S + 2), 1'b1);
        chk("abort.tgt_sck", tgt_sck, 2'b00);
        gap = lat;
        hk_sck = 1'b0;
        mon_clear();
        gap++;
        while (gap < 4) begin
            step(1);
            gap++;
        end
        chk("abort.byte_cnt", byte_cnt, 0);
        csb_start();
        host_byte(8'hC4, rx);
        host_byte(8'hA5, rx);
        csb_end();
        chk("b2b.busy", busy_seen, 1'b1);
        chk("b2b.csb_low", csb_low, 2'b01);
        chk("b2b.byte_cnt", byte_cnt, 1);
        chk("b2b.slv_first", s_cmd[0], 8'hA5);

        // Reset in the middle of a pass-thru.
        csb_start();
        host_byte(8'hC4, rx);
        chk("rst_mid.before", tgt_csb, 2'b10);
        resetn = 1'b0; hk_csb = 1'b1; hk_sck = 1'b0;
        step(1);
        chk("rst_mid.after", tgt_csb, 2'b11);
        chk("rst_mid.busy", busy, 1'b0);
        step(2);
        resetn = 1'b1;
        step(4);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] c;
            case ($urandom_range(0, 4))
                0:       c = 8'hC4;
                1:       c = 8'hC6;
                2:       c = 8'hC8;
                3:       c = 8'hC5;
                default: c = 8'($urandom);
            endcase
            run_vec(model(c, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 7)),
                    $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
